// File: rtl/lp_power_ctrl_pkg.sv
// Shared power-manager types and parameter defaults.
// Used by the sequencer top and its counters.
package lp_power_ctrl_pkg;

  typedef enum logic [1:0] {
    PM_RUN  = 2'd0,
    PM_STBY = 2'd1,
    PM_DEEP = 2'd2,
    PM_WAKE = 2'd3
  } pm_state_e;

  localparam int DEF_N_WAKE    = 4;
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_DEEP_IDLE = 1024;
  localparam int DEF_WAKE_CYC  = 3;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/lp_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable.
module lp_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lp_power_ctrl.sv
// Central low-power sequencer: RUN/STBY/DEEP/WAKE with
// per-bank retention, wake capture and lost-bank tracking.
module lp_power_ctrl
  import lp_power_ctrl_pkg::*;
#(
  parameter int N_WAKE           = DEF_N_WAKE,
  parameter int NUM_BANKS        = DEF_NUM_BANKS,
  parameter int DEEP_IDLE_CYCLES = DEF_DEEP_IDLE,
  parameter int WAKE_CYCLES      = DEF_WAKE_CYC,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wfi_req,
  input  logic [N_WAKE-1:0]    i_wake_src,
  input  logic [N_WAKE-1:0]    i_wake_en,
  input  logic [NUM_BANKS-1:0] i_bank_keep,
  input  logic                 i_lost_clr,
  output logic                 o_cpu_stall,
  output logic [NUM_BANKS-1:0] o_spram_standby,
  output logic [NUM_BANKS-1:0] o_spram_sleep,
  output logic [NUM_BANKS-1:0] o_spram_poweroff_n,
  output logic [N_WAKE-1:0]    o_wake_cause,
  output logic [NUM_BANKS-1:0] o_bank_lost,
  output logic [CNT_W-1:0]     o_sleep_cycles,
  output logic [1:0]           o_pm_state
);

  localparam int IW  = $clog2(DEEP_IDLE_CYCLES);
  localparam int WCW = $clog2(WAKE_CYCLES + 1);

  pm_state_e            r_state;
  pm_state_e            w_state_d;
  logic [WCW-1:0]       r_wcnt;
  logic [WCW-1:0]       w_wcnt_d;
  logic [N_WAKE-1:0]    r_cause;
  logic [N_WAKE-1:0]    w_cause_d;
  logic [NUM_BANKS-1:0] r_keep;
  logic [NUM_BANKS-1:0] w_keep_d;
  logic [NUM_BANKS-1:0] r_lost;
  logic [NUM_BANKS-1:0] w_lost_d;
  logic                 r_armed;
  logic                 w_armed_d;
  logic                 r_stall;
  logic                 w_stall_d;
  logic [NUM_BANKS-1:0] r_stby;
  logic [NUM_BANKS-1:0] w_stby_d;
  logic [NUM_BANKS-1:0] r_slp;
  logic [NUM_BANKS-1:0] w_slp_d;
  logic [NUM_BANKS-1:0] r_pon;
  logic [NUM_BANKS-1:0] w_pon_d;
  logic                 w_pend;
  logic                 w_clr;
  logic [IW-1:0]        w_idle;

  assign w_pend = |(i_wake_src & i_wake_en);

  lp_sat_counter #(.W(IW)) u_idle (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (r_state == PM_STBY),
    .o_cnt   (w_idle)
  );

  lp_sat_counter #(.W(CNT_W)) u_sleep (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    ((r_state == PM_STBY) || (r_state == PM_DEEP)),
    .o_cnt   (o_sleep_cycles)
  );

  always_comb begin
    w_state_d = r_state;
    w_wcnt_d  = r_wcnt;
    w_cause_d = r_cause;
    w_keep_d  = r_keep;
    w_lost_d  = i_lost_clr ? '0 : r_lost;
    w_armed_d = r_armed | ~i_wfi_req;
    w_clr     = 1'b0;
    unique case (r_state)
      PM_RUN: begin
        if (i_wfi_req && r_armed && !w_pend) begin
          w_state_d = PM_STBY;
          w_clr     = 1'b1;
        end
      end
      PM_STBY: begin
        // Wake beats the deep threshold on the same cycle.
        if (w_pend) begin
          w_state_d = PM_WAKE;
          w_wcnt_d  = WCW'(1);
          w_cause_d = i_wake_src & i_wake_en;
        end else if (w_idle == IW'(DEEP_IDLE_CYCLES - 1)) begin
          w_state_d = PM_DEEP;
          w_keep_d  = i_bank_keep;
          w_lost_d  = w_lost_d | ~i_bank_keep;
        end
      end
      PM_DEEP: begin
        if (w_pend) begin
          w_state_d = PM_WAKE;
          w_wcnt_d  = WCW'(WAKE_CYCLES);
          w_cause_d = i_wake_src & i_wake_en;
        end
      end
      PM_WAKE: begin
        if (r_wcnt == WCW'(1)) begin
          w_state_d = PM_RUN;
          w_armed_d = 1'b0;
        end else begin
          w_wcnt_d = r_wcnt - WCW'(1);
        end
      end
      default: w_state_d = PM_RUN;
    endcase
  end

  always_comb begin
    w_stby_d  = '0;
    w_slp_d   = '0;
    w_pon_d   = '1;
    w_stall_d = (w_state_d != PM_RUN);
    unique case (w_state_d)
      PM_STBY: w_stby_d = '1;
      PM_DEEP: begin
        w_stby_d = w_keep_d;
        w_slp_d  = w_keep_d;
        w_pon_d  = w_keep_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= PM_RUN;
      r_wcnt  <= '0;
      r_cause <= '0;
      r_keep  <= '1;
      r_lost  <= '0;
      r_armed <= 1'b1;
      r_stall <= 1'b0;
      r_stby  <= '0;
      r_slp   <= '0;
      r_pon   <= '1;
    end else begin
      r_state <= w_state_d;
      r_wcnt  <= w_wcnt_d;
      r_cause <= w_cause_d;
      r_keep  <= w_keep_d;
      r_lost  <= w_lost_d;
      r_armed <= w_armed_d;
      r_stall <= w_stall_d;
      r_stby  <= w_stby_d;
      r_slp   <= w_slp_d;
      r_pon   <= w_pon_d;
    end
  end

  assign o_cpu_stall        = r_stall;
  assign o_spram_standby    = r_stby;
  assign o_spram_sleep      = r_slp;
  assign o_spram_poweroff_n = r_pon;
  assign o_wake_cause       = r_cause;
  assign o_bank_lost        = r_lost;
  assign o_pm_state         = r_state;

endmodule

// File: tb/tb_lp_power_ctrl.sv
// Scenario bench for lp_power_ctrl with an expected
// pm_state queue popped once per clock.
module tb_lp_power_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wfi_req;
  logic [3:0]  wake_src;
  logic [3:0]  wake_en;
  logic [3:0]  bank_keep;
  logic        lost_clr;
  logic        cpu_stall;
  logic [3:0]  standby;
  logic [3:0]  sleep_o;
  logic [3:0]  pon;
  logic [3:0]  cause;
  logic [3:0]  lost;
  logic [15:0] scyc;
  logic [1:0]  pm;

  int checks = 0;
  int errors = 0;
  logic [1:0] q_exp[$];
  logic [3:0] exp_lost;

  always #5 clk = ~clk;

  lp_power_ctrl #(
    .N_WAKE(4), .NUM_BANKS(4),
    .DEEP_IDLE_CYCLES(8), .WAKE_CYCLES(3), .CNT_W(16)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_wfi_req          (wfi_req),
    .i_wake_src         (wake_src),
    .i_wake_en          (wake_en),
    .i_bank_keep        (bank_keep),
    .i_lost_clr         (lost_clr),
    .o_cpu_stall        (cpu_stall),
    .o_spram_standby    (standby),
    .o_spram_sleep      (sleep_o),
    .o_spram_poweroff_n (pon),
    .o_wake_cause       (cause),
    .o_bank_lost        (lost),
    .o_sleep_cycles     (scyc),
    .o_pm_state         (pm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wfi_req = 1'b0; wake_src = '0; wake_en = '0;
    bank_keep = '1; lost_clr = 1'b0;
    #12;
    checks++;
    if ({pm, cpu_stall, standby, sleep_o, pon, cause, lost, scyc}
        !== {2'd0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 16'd0}) begin
      errors++;
      $display("FAIL reset: pm=%0d stall=%b stby=%b slp=%b pon=%b cause=%b lost=%b scyc=%0d",
               pm, cpu_stall, standby, sleep_o, pon, cause, lost, scyc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_lost = '0;
  endtask

  task automatic test_stby_wake();
    logic [1:0] e;
    int ns = 0;
    wake_en = 4'b0001; wake_src = '0; wfi_req = 1'b1;
    q_exp = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      step();
      e = q_exp.pop_front();
      if (e == 2'd1 || e == 2'd2) ns++;
      checks++;
      if (pm !== e) begin
        errors++;
        $display("FAIL stby_wake state[%0d]: got %0d want %0d", i, pm, e);
      end
      if (i == 0) begin
        checks++;
        if ({cpu_stall, standby, pon} !== {1'b1, 4'hF, 4'hF}) begin
          errors++;
          $display("FAIL stby_pins: stall=%b stby=%b pon=%b", cpu_stall, standby, pon);
        end
      end
      if (i == 2) wake_src = 4'b0001;
    end
    checks++;
    if (cause !== 4'b0001 || scyc !== 16'(ns)) begin
      errors++;
      $display("FAIL stby_wake cause/cycles: got %b/%0d want 0001/%0d", cause, scyc, ns);
    end
    wfi_req = 1'b0; wake_src = '0;
    step();
  endtask

  task automatic test_deep();
    logic [1:0] e;
    int ns = 0;
    wake_en = 4'b0110; wake_src = '0; bank_keep = 4'b0011; wfi_req = 1'b1;
    for (int i = 0; i < 8; i++) q_exp.push_back(2'd1);
    for (int i = 0; i < 3; i++) q_exp.push_back(2'd2);
    for (int i = 0; i < 3; i++) q_exp.push_back(2'd3);
    q_exp.push_back(2'd0);
    exp_lost = exp_lost | ~bank_keep;
    for (int i = 0; i < 15; i++) begin
      step();
      e = q_exp.pop_front();
      if (e == 2'd1 || e == 2'd2) ns++;
      checks++;
      if (pm !== e) begin
        errors++;
        $display("FAIL deep state[%0d]: got %0d want %0d", i, pm, e);
      end
      if (i == 8) bank_keep = 4'b1111;
      if (i == 9) begin
        checks++;
        if ({standby, sleep_o, pon, lost, cpu_stall}
            !== {4'b0011, 4'b0011, 4'b0011, exp_lost, 1'b1}) begin
          errors++;
          $display("FAIL deep_pins: stby=%b slp=%b pon=%b lost=%b stall=%b",
                   standby, sleep_o, pon, lost, cpu_stall);
        end
      end
      if (i == 10) wake_src = 4'b0100;
      if (i == 11) begin
        wake_src = 4'b0010;
        checks++;
        if ({standby, sleep_o, pon, cpu_stall} !== {4'h0, 4'h0, 4'hF, 1'b1}) begin
          errors++;
          $display("FAIL wake_pins: stby=%b slp=%b pon=%b stall=%b",
                   standby, sleep_o, pon, cpu_stall);
        end
      end
    end
    checks++;
    if (cause !== 4'b0100 || scyc !== 16'(ns)) begin
      errors++;
      $display("FAIL deep_wake cause/cycles: got %b/%0d want 0100/%0d", cause, scyc, ns);
    end
    wfi_req = 1'b0; wake_src = '0;
    step();
  endtask

  task automatic test_wake_on_threshold();
    logic [1:0] e;
    wake_en = 4'b0001; wake_src = '0; bank_keep = 4'b0000; wfi_req = 1'b1;
    for (int i = 0; i < 8; i++) q_exp.push_back(2'd1);
    q_exp.push_back(2'd3);
    q_exp.push_back(2'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      e = q_exp.pop_front();
      checks++;
      if (pm !== e) begin
        errors++;
        $display("FAIL thresh state[%0d]: got %0d want %0d", i, pm, e);
      end
      if (i == 7) wake_src = 4'b0001;
    end
    checks++;
    if (lost !== exp_lost || scyc !== 16'd8) begin
      errors++;
      $display("FAIL thresh lost/cycles: got %b/%0d want %b/8", lost, scyc, exp_lost);
    end
    wake_src = '0;
  endtask

  task automatic test_rearm();
    logic [1:0] e;
    q_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 7; i++) begin
      if (i == 3) wfi_req = 1'b0;
      if (i == 4) wfi_req = 1'b1;
      if (i == 5) wake_src = 4'b0001;
      step();
      e = q_exp.pop_front();
      checks++;
      if (pm !== e) begin
        errors++;
        $display("FAIL rearm state[%0d]: got %0d want %0d", i, pm, e);
      end
    end
    wfi_req = 1'b0; wake_src = '0;
    step();
  endtask

  task automatic test_masked_lost();
    logic [1:0] e;
    wake_en = 4'b0111; wake_src = 4'b1000; bank_keep = 4'b1010; wfi_req = 1'b1;
    for (int i = 0; i < 8; i++) q_exp.push_back(2'd1);
    q_exp.push_back(2'd2);
    q_exp.push_back(2'd2);
    exp_lost = exp_lost | ~bank_keep;
    for (int i = 0; i < 10; i++) begin
      step();
      e = q_exp.pop_front();
      checks++;
      if (pm !== e) begin
        errors++;
        $display("FAIL masked state[%0d]: got %0d want %0d", i, pm, e);
      end
    end
    checks++;
    if (lost !== exp_lost || pon !== 4'b1010) begin
      errors++;
      $display("FAIL masked lost/pon: got %b/%b want %b/1010", lost, pon, exp_lost);
    end
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    exp_lost = '0;
    checks++;
    if (lost !== exp_lost || pm !== 2'd2) begin
      errors++;
      $display("FAIL lost_clr: got lost=%b pm=%0d want 0000/2", lost, pm);
    end
  endtask

  task automatic test_reset_deep();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pon, cpu_stall, pm, lost, sleep_o}
        !== {4'hF, 1'b0, 2'd0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_deep: pon=%b stall=%b pm=%0d lost=%b slp=%b",
               pon, cpu_stall, pm, lost, sleep_o);
    end
    wfi_req = 1'b0; wake_src = '0; wake_en = '0; bank_keep = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    wfi_req = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if ({pm, pon, lost} !== {2'd2, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL reset_deep re-entry: pm=%0d pon=%b lost=%b", pm, pon, lost);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pon, cpu_stall, pm, lost} !== {4'hF, 1'b0, 2'd0, 4'h0}) begin
      errors++;
      $display("FAIL reset_deep2: pon=%b stall=%b pm=%0d lost=%b",
               pon, cpu_stall, pm, lost);
    end
  endtask

  initial begin
    test_reset();
    test_stby_wake();
    test_deep();
    test_wake_on_threshold();
    test_rearm();
    test_masked_lost();
    test_reset_deep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
